// File: rtl/uart_pkg.sv
// Shared types and frame layout for the UART receive deframer and its FIFO.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    WRITE,
    WAIT_LOW
  } deframe_state_t;

  localparam int FRAME_W   = 11;
  localparam int DATA_W    = 8;
  localparam int START_IDX = 0;
  localparam int PAR_IDX   = 9;
  localparam int STOP_IDX  = 10;

  typedef struct packed {
    logic              par_err;
    logic              frame_err;
    logic [DATA_W-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Circular-buffer FIFO for deframed entries; a push into a full FIFO is
// accepted only when a pop happens on the same edge.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             baud_clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; stale contents are never visible because rdata is gated by empty.
  always_ff @(posedge baud_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_deframe.sv
// UART receive deframer: checks start/stop/parity of each SIPO frame and queues
// {par_err, frame_err, data}. Parity checking is enabled by UART_DEFRAME_PARITY_EN.
module uart_deframe
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic               baud_clk,
  input  logic               reset_n,
  input  logic               recieved_flag,
  input  logic [FRAME_W-1:0] data_parll,
  input  logic               parity_type,
  input  logic               rd_en,
  input  logic               err_clr,
  output logic [DATA_W-1:0]  rx_data,
  output logic               rx_valid,
  output logic               frame_error,
  output logic               parity_error,
  output logic               fifo_full,
  output logic               overrun_error
);

  deframe_state_t     state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  rx_entry_t          entry_q, entry_d;
  rx_entry_t          head;
  logic               overrun_q, overrun_d;
  logic               par_err, push, fifo_empty, overrun_set;

`ifdef UART_DEFRAME_PARITY_EN
  assign par_err = (^frame_q[PAR_IDX:START_IDX+1]) ^ parity_type;
`else
  logic unused_par;
  assign unused_par = parity_type ^ frame_q[PAR_IDX];
  assign par_err    = 1'b0;
`endif

  assign push        = (state_q == WRITE);
  // A pop in the same cycle makes room, so the frame is not lost.
  assign overrun_set = push & fifo_full & ~rd_en;

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    entry_d = entry_q;
    unique case (state_q)
      IDLE: begin
        if (recieved_flag) begin
          frame_d = data_parll;
          state_d = CHECK;
        end
      end
      CHECK: begin
        entry_d.data      = frame_q[PAR_IDX-1:START_IDX+1];
        entry_d.frame_err = frame_q[START_IDX] | ~frame_q[STOP_IDX];
        entry_d.par_err   = par_err;
        state_d           = WRITE;
      end
      WRITE:    state_d = WAIT_LOW;
      WAIT_LOW: if (!recieved_flag) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    overrun_d = overrun_q;
    if (err_clr)     overrun_d = 1'b0;
    if (overrun_set) overrun_d = 1'b1;
  end

  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      entry_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      entry_q   <= entry_d;
      overrun_q <= overrun_d;
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(rx_entry_t))
  ) u_fifo (
    .baud_clk (baud_clk),
    .reset_n  (reset_n),
    .push     (push),
    .pop      (rd_en),
    .wdata    (entry_q),
    .rdata    (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign rx_valid      = ~fifo_empty;
  assign rx_data       = head.data;
  assign frame_error   = head.frame_err;
  assign parity_error  = head.par_err;
  assign overrun_error = overrun_q;

endmodule

// File: tb/tb_uart_deframe.sv
// Scoreboard bench for uart_deframe: a queue-based model of the receive FIFO
// predicts every popped entry and the full/overrun flags.
module tb_uart_deframe;

  localparam int DEPTH = 4;

  logic        baud_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        recieved_flag = 1'b0;
  logic [10:0] data_parll = '0;
  logic        parity_type = 1'b0;
  logic        rd_en = 1'b0;
  logic        err_clr = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_valid, frame_error, parity_error, fifo_full, overrun_error;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  exp_t sb[$];
  bit   exp_ovr = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  uart_deframe #(.FIFO_DEPTH(DEPTH)) dut (
    .baud_clk      (baud_clk),
    .reset_n       (reset_n),
    .recieved_flag (recieved_flag),
    .data_parll    (data_parll),
    .parity_type   (parity_type),
    .rd_en         (rd_en),
    .err_clr       (err_clr),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .frame_error   (frame_error),
    .parity_error  (parity_error),
    .fifo_full     (fifo_full),
    .overrun_error (overrun_error)
  );

  always #5 baud_clk = ~baud_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a frame is good when start is 0 and stop is 1; with parity
  // enabled the nine bits [9:1] must hold an even (or odd) number of ones.
  function automatic exp_t model(input logic [10:0] f, input logic pt);
    exp_t e;
    e.data = f[8:1];
    e.ferr = (f[0] != 1'b0) || (f[10] != 1'b1);
`ifdef UART_DEFRAME_PARITY_EN
    e.perr = (($countones(f[9:1]) % 2) != (pt ? 1 : 0));
`else
    e.perr = 1'b0;
`endif
    return e;
  endfunction

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic pt);
    logic par;
    par = pt ? ~(^d) : ^d;
    return {1'b1, par, d, 1'b0};
  endfunction

  task automatic tick();
    @(posedge baud_clk);
    #2;
  endtask

  task automatic check_state(input string tag);
    check({tag, " rx_valid"}, rx_valid, sb.size() > 0);
    check({tag, " fifo_full"}, fifo_full, sb.size() == DEPTH);
    check({tag, " overrun"}, overrun_error, exp_ovr);
    if (sb.size() > 0) begin
      check({tag, " rx_data"}, rx_data, sb[0].data);
      check({tag, " frame_error"}, frame_error, sb[0].ferr);
      check({tag, " parity_error"}, parity_error, sb[0].perr);
    end else begin
      check({tag, " empty head"}, {rx_data, frame_error, parity_error}, 0);
    end
  endtask

  task automatic send_frame(input logic [10:0] f, input logic pt, input int hold,
                            input bit pop_in_write, input bit clr_in_write);
    bit   was_empty;
    bit   dropped;
    exp_t e;
    was_empty = (sb.size() == 0);
    e         = model(f, pt);
    dropped   = (sb.size() >= DEPTH) && !pop_in_write;
    if (!dropped) sb.push_back(e);
    data_parll    = f;
    parity_type   = pt;
    recieved_flag = 1'b1;
    tick();                        // edge N: frame latched
    tick();                        // edge N+1: check registered
    parity_type = 1'($urandom);    // must not affect the entry already checked
    if (was_empty) check("pre_push rx_valid", rx_valid, 1'b0);
    if (pop_in_write) rd_en = 1'b1;
    if (clr_in_write) err_clr = 1'b1;
    tick();                        // edge N+2: push
    rd_en   = 1'b0;
    err_clr = 1'b0;
    if (dropped) exp_ovr = 1'b1;
    else if (clr_in_write) exp_ovr = 1'b0;
    if (was_empty) check("post_push rx_valid", rx_valid, 1'b1);
    for (int i = 3; i < hold; i++) tick();
    recieved_flag = 1'b0;
    tick();
    tick();
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    exp_ovr = 1'b0;
  endtask

  // Monitor: every accepted pop is compared against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge baud_clk);
      if (reset_n && rd_en && rx_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL pop_unexpected: got rx_data 0x%0h, required no entry", rx_data);
        end else begin
          e = sb.pop_front();
          check("mon rx_data", rx_data, e.data);
          check("mon frame_error", frame_error, e.ferr);
          check("mon parity_error", parity_error, e.perr);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] f;
    logic        pt;

    tick();
    tick();
    check_state("reset");
    reset_n = 1'b1;
    tick();
    check_state("after_reset");

    send_frame(11'h4AA, 1'b0, 16, 0, 0);
    check_state("good_frame");
    pop();
    check_state("good_drained");

    send_frame(11'h0AA, 1'b0, 16, 0, 0);
    check_state("stop_zero");
    pop();
    send_frame(11'h4AB, 1'b0, 16, 0, 0);
    check_state("start_one");
    pop();

    send_frame(11'h6AA, 1'b0, 16, 0, 0);
    check_state("par_even");
    pop();
    send_frame(11'h6AA, 1'b1, 16, 0, 0);
    check_state("par_odd");
    pop();

    for (int i = 1; i <= 5; i++) begin
      send_frame(mk_frame(8'(i), 1'b0), 1'b0, 16, 0, 0);
      if (i == 4) check_state("fill4");
    end
    check_state("overrun");
    for (int i = 0; i < 4; i++) pop();
    check_state("drained_ovr");
    clear_err();
    check_state("err_cleared");

    for (int i = 0; i < 4; i++) send_frame(mk_frame(8'(8'h10 + i), 1'b0), 1'b0, 5, 0, 0);
    send_frame(mk_frame(8'h20, 1'b0), 1'b0, 5, 1, 0);
    check_state("full_pop_push");
    send_frame(mk_frame(8'h21, 1'b0), 1'b0, 5, 0, 1);
    check_state("clr_vs_set");
    for (int i = 0; i < 4; i++) pop();
    clear_err();
    check_state("drain2");

    send_frame(mk_frame(8'hA1, 1'b0), 1'b0, 6, 0, 0);
    send_frame(mk_frame(8'hA2, 1'b0), 1'b0, 6, 0, 0);
    data_parll    = mk_frame(8'hA3, 1'b0);
    recieved_flag = 1'b1;
    tick();
    reset_n = 1'b0;
    sb.delete();
    exp_ovr = 1'b0;
    #1;
    check_state("reset_mid_check");
    recieved_flag = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check_state("post_reset_idle");
    send_frame(mk_frame(8'h3C, 1'b1), 1'b1, 8, 0, 0);
    check_state("post_reset_frame");
    pop();

    for (int it = 0; it < 150; it++) begin
      f  = 11'($urandom);
      pt = 1'($urandom);
      if ($urandom_range(3) != 0) begin
        f[0]  = 1'b0;
        f[10] = 1'b1;
      end
      send_frame(f, pt, $urandom_range(20, 3),
                 (sb.size() == DEPTH) && ($urandom_range(1) == 1),
                 $urandom_range(7) == 0);
      check_state("rand");
      for (int k = $urandom_range(2); k > 0; k--) pop();
      if (exp_ovr && $urandom_range(3) == 0) clear_err();
    end

    while (sb.size() > 0) pop();
    check_state("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
